// File: rtl/rv_pkg.sv
// Shared core constants: writeback source selects, load funct3 encodings and datapath width.
package rv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks byte/halfword/word from the memory word and extends it.
module load_align #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            legal
);
   import rv_pkg::*;

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = word[{offset, 3'b000} +: 8];
   // Misaligned halfwords are not trapped; only offset[1] chooses the half.
   assign w_half = offset[1] ? word[31:16] : word[15:0];

   always_comb begin
      data  = '0;
      legal = 1'b1;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
         F3_LW:   data = word;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: MEM/WB register, result select, register file write port, forwarding and
// retired-instruction counter.
module regfile_writeback #(
   parameter int unsigned XLEN  = rv_pkg::XLEN,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_rd,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_funct3,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [XLEN-1:0]  mem_load_word,
   input  logic [XLEN-1:0]  mem_pc_plus4,
   input  logic [XLEN-1:0]  mem_imm,
   input  logic             stall,
   input  logic             flush,
   output logic [4:0]       writereg_addr,
   output logic [XLEN-1:0]  writedata,
   output logic             regwrite,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic [CNT_W-1:0] instret
);
   import rv_pkg::*;

   logic             r_valid;
   logic             r_we;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_data;
   logic [CNT_W-1:0] r_instret;

   logic [XLEN-1:0]  w_load;
   logic             w_legal;
   logic [XLEN-1:0]  w_sel_data;
   logic             w_we;
   logic             w_retire;

   load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .word   (mem_load_word),
      .offset (mem_alu_result[1:0]),
      .funct3 (mem_funct3),
      .data   (w_load),
      .legal  (w_legal)
   );

   always_comb begin
      w_sel_data = '0;
      case (mem_wb_sel)
         WB_ALU:  w_sel_data = mem_alu_result;
         WB_LOAD: w_sel_data = w_load;
         WB_PC4:  w_sel_data = mem_pc_plus4;
         WB_IMM:  w_sel_data = mem_imm;
         default: w_sel_data = '0;
      endcase
   end

   // An illegal load funct3 suppresses the write at capture time.
   assign w_we     = mem_regwrite & ((mem_wb_sel != WB_LOAD) | w_legal);
   assign w_retire = mem_valid & ~flush & ~stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else if (!stall) begin
         r_valid <= mem_valid;
         r_we    <= w_we;
         r_rd    <= mem_rd;
         r_data  <= w_sel_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign regwrite      = r_valid & r_we & (r_rd != 5'd0);
   assign writereg_addr = r_rd;
   assign writedata     = r_data;
   assign fwd_valid     = regwrite;
   assign fwd_rd        = r_rd;
   assign fwd_data      = r_data;
   assign instret       = r_instret;

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage of the pipelined RISC-V core and the sole writer of the register file. It holds the MEM/WB pipeline register and selects the result source. It aligns and sign-extends load data, then drives the register file write port (`writereg_addr`, `writedata`, `regwrite`). It also exports the same write as a forwarding source and keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, data path width.
- `CNT_W`, 32, retired-instruction counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. Asserted when 0.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_regwrite`  in  1  instruction writes `rd`.
- `mem_rd`  in  5  destination register.
- `mem_wb_sel`  in  2  result source (see Operation).
- `mem_funct3`  in  3  load size/sign.
- `mem_alu_result`  in  XLEN  ALU result. Bits [1:0] are the load byte offset.
- `mem_load_word`  in  XLEN  raw 32-bit word from data memory.
- `mem_pc_plus4`  in  XLEN  link value.
- `mem_imm`  in  XLEN  U-type immediate.
- `stall`  in  1  hold the stage contents.
- `flush`  in  1  load a bubble.
- `writereg_addr`  out  5  register file write address.
- `writedata`  out  XLEN  register file write data.
- `regwrite`  out  1  register file write enable.
- `fwd_valid`  out  1  equals `regwrite`.
- `fwd_rd`  out  5  equals `writereg_addr`.
- `fwd_data`  out  XLEN  equals `writedata`.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- Source select (`mem_wb_sel`):
  - 00: ALU result.
  - 01: aligned load data.
  - 10: PC+4.
  - 11: immediate.
- Load alignment is combinational and happens before the stage register. Byte offset `off = mem_alu_result[1:0]`.
  - funct3 000 (LB): byte `off`, sign-extended.
  - 100 (LBU): byte `off`, zero-extended.
  - 001 (LH): halfword `mem_alu_result[1]`, sign-extended.
  - 101 (LHU): same halfword, zero-extended.
  - 010 (LW): full word.
  - Other funct3 values: result 0 and write suppressed.
  - Misaligned halfword (bit 0 = 1) is not trapped. Only bit 1 selects.
- Stage register update on each rising edge:
  - `flush`=1: load a bubble (valid=0, write=0). `flush` takes priority over `stall`.
  - else `stall`=1: hold all contents.
  - else: capture the MEM inputs and the selected, aligned data.
- Write qualification: `regwrite = stage_valid & stage_regwrite & (stage_rd != 0)`.
  - A write to x0 is never issued.
  - `writereg_addr` and `writedata` still show the captured values.
- `instret` increments by 1 on each edge that captures `mem_valid`=1 while `flush`=0 and `stall`=0. It wraps modulo 2^CNT_W without saturating.
- A held (stalled) instruction keeps `regwrite` asserted. The repeated identical register file write is harmless and is the intended behaviour.

## Timing
- Reset (`rst`=0, asynchronous) clears all outputs immediately, stage valid, and `instret`:
  - `regwrite`=0, `writereg_addr`=0, `writedata`=0, `fwd_*`=0, `instret`=0.
- Reset mid-stall or mid-flush: reset wins, and the stage is empty after release.
- Latency:
  - MEM inputs presented before edge N drive `regwrite`/`writedata` during cycle N to N+1. This is registered, with no combinational path from `mem_*` to outputs.
  - The register file captures the value at edge N+1.
- Forwarding outputs are valid in the same cycle as `regwrite`. Decode reads of `fwd_rd` must bypass in that cycle.
- Simultaneous `stall`=1 and `flush`=1: a bubble is loaded and `instret` does not increment.

## Structure
- Shared package `rv_pkg` holds:
  - `WB_ALU`, `WB_LOAD`, `WB_PC4`, `WB_IMM` (2-bit).
  - `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - `XLEN`.
- One combinational sub-module, `load_align`, with inputs (word, offset, funct3) and outputs (data, legal). The stage register and counter stay in `regfile_writeback`.

## Test plan
- Reset then release, with `mem_valid`=1, `mem_regwrite`=1, `mem_rd`=5, `mem_wb_sel`=00, `mem_alu_result`=0x0000_1234 → one cycle later `regwrite`=1, `writereg_addr`=5, `writedata`=0x1234, `instret`=1.
- Loads with `mem_load_word`=0x80FF_7F01:
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=3 → 0x0000_0080.
  - LH off=2 → 0xFFFF_80FF.
  - LHU off=0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
  - funct3=011 → `regwrite`=0.
- `mem_rd`=0, `mem_wb_sel`=10, `mem_pc_plus4`=0x104 → `regwrite`=0, `writedata`=0x104, `instret` still increments.
- Capture rd=7/0xAA, then `stall`=1 for 3 cycles while inputs change to rd=8 → outputs stay rd=7/0xAA, `instret` unchanged; when the stall is released, rd=8 appears.
- `flush`=1 together with `stall`=1 and a valid input → next cycle `regwrite`=0, `fwd_valid`=0, `instret` unchanged.
- Preload `instret` near the wrap (CNT_W=4 build, 15 retires) then retire one more → `instret`=0. Assert `rst`=0 mid-cycle → all outputs are 0 immediately, without waiting for a clock edge.
